// File: rtl/cpumc_bus_arbiter.sv
// CPU memory-controller bus arbiter: shares cpumc_a/r_nw/din between the rp2a03, HCI and PRG loader,
// stalling the CPU via rdy and inserting an idle turnaround between owners.
module cpumc_bus_arbiter #(
  parameter int unsigned DRAIN_MAX    = 16,
  parameter int unsigned TURN_CYCLES  = 2,
  parameter int unsigned LDR_MAX_HOLD = 256
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [15:0] cpu_a_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  cpu_d_in,
  output logic        cpu_rdy_out,
  input  logic        hci_req_in,
  output logic        hci_gnt_out,
  input  logic [15:0] hci_a_in,
  input  logic        hci_r_nw_in,
  input  logic [7:0]  hci_d_in,
  input  logic        ldr_req_in,
  output logic        ldr_gnt_out,
  input  logic [15:0] ldr_a_in,
  input  logic        ldr_r_nw_in,
  input  logic [7:0]  ldr_d_in,
  output logic [15:0] bus_a_out,
  output logic        bus_r_nw_out,
  output logic [7:0]  bus_d_out,
  output logic [1:0]  owner_out
);

  localparam int unsigned DW = $clog2(DRAIN_MAX + 1);
  localparam int unsigned TW = $clog2(TURN_CYCLES + 1);
  localparam int unsigned HW = $clog2(LDR_MAX_HOLD + 1);

  typedef enum logic [2:0] {S_CPU, S_DRAIN, S_OWN_HCI, S_OWN_LDR, S_TURN} state_t;
  typedef enum logic [1:0] {OWN_CPU, OWN_HCI, OWN_LDR, OWN_NONE} owner_t;

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic          rdy_q, rdy_d;
  logic          hgnt_q, hgnt_d;
  logic          lgnt_q, lgnt_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [TW-1:0] turn_q, turn_d;
  logic [HW-1:0] hold_q, hold_d;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_CPU;
      owner_q <= OWN_CPU;
      rdy_q   <= 1'b1;
      hgnt_q  <= 1'b0;
      lgnt_q  <= 1'b0;
      drain_q <= '0;
      turn_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rdy_q   <= rdy_d;
      hgnt_q  <= hgnt_d;
      lgnt_q  <= lgnt_d;
      drain_q <= drain_d;
      turn_q  <= turn_d;
      hold_q  <= hold_d;
    end
  end

  // Counters default to zero so each one clears automatically whenever its state is left.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rdy_d   = rdy_q;
    hgnt_d  = hgnt_q;
    lgnt_d  = lgnt_q;
    drain_d = '0;
    turn_d  = '0;
    hold_d  = '0;
    unique case (state_q)
      S_CPU: begin
        if (hci_req_in || ldr_req_in) begin
          state_d = S_DRAIN;
          rdy_d   = 1'b0;
        end
      end
      S_DRAIN: begin
        if (!hci_req_in && !ldr_req_in) begin
          state_d = S_CPU;
          rdy_d   = 1'b1;
        end else if (cpu_r_nw_in || drain_q == DW'(DRAIN_MAX - 1)) begin
          if (hci_req_in) begin
            state_d = S_OWN_HCI;
            owner_d = OWN_HCI;
            hgnt_d  = 1'b1;
          end else begin
            state_d = S_OWN_LDR;
            owner_d = OWN_LDR;
            lgnt_d  = 1'b1;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_OWN_HCI: begin
        if (!hci_req_in) begin
          state_d = S_TURN;
          owner_d = OWN_NONE;
          hgnt_d  = 1'b0;
        end
      end
      S_OWN_LDR: begin
        if (!ldr_req_in || (hci_req_in && hold_q == HW'(LDR_MAX_HOLD - 1))) begin
          state_d = S_TURN;
          owner_d = OWN_NONE;
          lgnt_d  = 1'b0;
        end else if (hci_req_in) begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_TURN: begin
        if (turn_q == TW'(TURN_CYCLES - 1)) begin
          if (hci_req_in) begin
            state_d = S_OWN_HCI;
            owner_d = OWN_HCI;
            hgnt_d  = 1'b1;
          end else if (ldr_req_in) begin
            state_d = S_OWN_LDR;
            owner_d = OWN_LDR;
            lgnt_d  = 1'b1;
          end else begin
            state_d = S_CPU;
            owner_d = OWN_CPU;
            rdy_d   = 1'b1;
          end
        end else begin
          turn_d = turn_q + 1'b1;
        end
      end
      default: begin
        state_d = S_CPU;
        owner_d = OWN_CPU;
        rdy_d   = 1'b1;
        hgnt_d  = 1'b0;
        lgnt_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    bus_a_out    = '0;
    bus_r_nw_out = 1'b1;
    bus_d_out    = '0;
    unique case (owner_q)
      OWN_CPU: begin
        bus_a_out    = cpu_a_in;
        bus_r_nw_out = cpu_r_nw_in;
        bus_d_out    = cpu_d_in;
      end
      OWN_HCI: begin
        bus_a_out    = hci_a_in;
        bus_r_nw_out = hci_r_nw_in;
        bus_d_out    = hci_d_in;
      end
      OWN_LDR: begin
        bus_a_out    = ldr_a_in;
        bus_r_nw_out = ldr_r_nw_in;
        bus_d_out    = ldr_d_in;
      end
      default: begin
        bus_a_out    = '0;
        bus_r_nw_out = 1'b1;
        bus_d_out    = '0;
      end
    endcase
  end

  assign cpu_rdy_out = rdy_q;
  assign hci_gnt_out = hgnt_q;
  assign ldr_gnt_out = lgnt_q;
  assign owner_out   = owner_q;

endmodule

// File: tb/tb_cpumc_bus_arbiter.sv
// Bench for cpumc_bus_arbiter: a timestamp-based ownership model checked every cycle,
// plus directed scenarios with hand-computed latencies.
module tb_cpumc_bus_arbiter;

  localparam int DRAIN_MAX    = 16;
  localparam int TURN_CYCLES  = 2;
  localparam int LDR_MAX_HOLD = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_a = 16'h8000;
  logic        cpu_r_nw = 1'b1;
  logic [7:0]  cpu_d = 8'h11;
  logic        cpu_rdy;
  logic        hci_req = 1'b0;
  logic        hci_gnt;
  logic [15:0] hci_a = 16'h0700;
  logic        hci_r_nw = 1'b1;
  logic [7:0]  hci_d = 8'h22;
  logic        ldr_req = 1'b0;
  logic        ldr_gnt;
  logic [15:0] ldr_a = 16'hC000;
  logic        ldr_r_nw = 1'b0;
  logic [7:0]  ldr_d = 8'h5A;
  logic [15:0] bus_a;
  logic        bus_r_nw;
  logic [7:0]  bus_d;
  logic [1:0]  owner;

  int n_checks = 0;
  int n_err = 0;

  cpumc_bus_arbiter #(
    .DRAIN_MAX(DRAIN_MAX),
    .TURN_CYCLES(TURN_CYCLES),
    .LDR_MAX_HOLD(LDR_MAX_HOLD)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .cpu_a_in(cpu_a), .cpu_r_nw_in(cpu_r_nw), .cpu_d_in(cpu_d), .cpu_rdy_out(cpu_rdy),
    .hci_req_in(hci_req), .hci_gnt_out(hci_gnt), .hci_a_in(hci_a), .hci_r_nw_in(hci_r_nw),
    .hci_d_in(hci_d),
    .ldr_req_in(ldr_req), .ldr_gnt_out(ldr_gnt), .ldr_a_in(ldr_a), .ldr_r_nw_in(ldr_r_nw),
    .ldr_d_in(ldr_d),
    .bus_a_out(bus_a), .bus_r_nw_out(bus_r_nw), .bus_d_out(bus_d), .owner_out(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus, whether the CPU is being drained, and the cycle at which the
  // current drain/turnaround began or HCI began waiting on the loader.
  int m_cyc = 0;
  int m_owner = 0;
  bit m_drain = 1'b0;
  int m_start = 0;
  int m_hsince = -1;

  always @(posedge clk) begin
    m_cyc++;
    if (!rst_n) begin
      m_owner = 0; m_drain = 1'b0; m_hsince = -1;
    end else if (m_drain) begin
      if (!hci_req && !ldr_req) m_drain = 1'b0;
      else if (cpu_r_nw || (m_cyc - m_start) == DRAIN_MAX) begin
        m_drain = 1'b0;
        m_owner = hci_req ? 1 : 2;
        m_hsince = -1;
      end
    end else if (m_owner == 0) begin
      if (hci_req || ldr_req) begin m_drain = 1'b1; m_start = m_cyc; end
    end else if (m_owner == 1) begin
      if (!hci_req) begin m_owner = 3; m_start = m_cyc; end
    end else if (m_owner == 2) begin
      if (!hci_req) m_hsince = -1;
      else if (m_hsince < 0) m_hsince = m_cyc;
      if (!ldr_req || (hci_req && (m_cyc - m_hsince) == LDR_MAX_HOLD - 1)) begin
        m_owner = 3; m_start = m_cyc; m_hsince = -1;
      end
    end else begin
      if ((m_cyc - m_start) == TURN_CYCLES) m_owner = hci_req ? 1 : (ldr_req ? 2 : 0);
    end
    #1;
    chk("m_rdy", cpu_rdy, (m_owner == 0 && !m_drain));
    chk("m_hci_gnt", hci_gnt, (m_owner == 1));
    chk("m_ldr_gnt", ldr_gnt, (m_owner == 2));
    chk("m_owner", owner, m_owner);
    chk("m_one_gnt", hci_gnt & ldr_gnt, 0);
    case (m_owner)
      0: begin chk("m_bus_a", bus_a, cpu_a); chk("m_bus_rnw", bus_r_nw, cpu_r_nw); chk("m_bus_d", bus_d, cpu_d); end
      1: begin chk("m_bus_a", bus_a, hci_a); chk("m_bus_rnw", bus_r_nw, hci_r_nw); chk("m_bus_d", bus_d, hci_d); end
      2: begin chk("m_bus_a", bus_a, ldr_a); chk("m_bus_rnw", bus_r_nw, ldr_r_nw); chk("m_bus_d", bus_d, ldr_d); end
      default: begin chk("m_bus_a", bus_a, 0); chk("m_bus_rnw", bus_r_nw, 1); chk("m_bus_d", bus_d, 0); end
    endcase
  end

  function automatic logic sel(input int which);
    case (which)
      0: return hci_gnt;
      1: return ldr_gnt;
      2: return cpu_rdy;
      default: return !ldr_gnt;
    endcase
  endfunction

  // Counts negedges until the selected condition holds; k exceeds budget on timeout.
  task automatic wait_for(input int which, input int budget, output int k);
    for (k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (sel(which)) break;
    end
  endtask

  initial begin
    int k;
    // 1: reset and CPU pass-through
    @(negedge clk);
    #1;
    chk("rst_rdy", cpu_rdy, 1);
    chk("rst_owner", owner, 0);
    chk("rst_gnts", {hci_gnt, ldr_gnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t1_bus_a", bus_a, 16'h8000);
    chk("t1_rdy", cpu_rdy, 1);
    chk("t1_owner", owner, 0);

    // 2: HCI waits for a CPU read cycle
    cpu_r_nw = 1'b0; hci_req = 1'b1;
    @(negedge clk);
    chk("t2_rdy_low", cpu_rdy, 0);
    chk("t2_drain_bus_a", bus_a, 16'h8000);
    @(negedge clk);
    @(negedge clk);
    chk("t2_no_gnt_yet", hci_gnt, 0);
    cpu_r_nw = 1'b1;
    @(negedge clk);
    chk("t2_hci_gnt", hci_gnt, 1);
    chk("t2_bus_a", bus_a, 16'h0700);
    hci_req = 1'b0; cpu_r_nw = 1'b0; cpu_a = 16'h1234;
    @(negedge clk);
    chk("t2_turn1_owner", owner, 3);
    chk("t2_turn1_rnw", bus_r_nw, 1);
    chk("t2_turn1_a", bus_a, 0);
    @(negedge clk);
    chk("t2_turn2_owner", owner, 3);
    chk("t2_turn2_rdy", cpu_rdy, 0);
    @(negedge clk);
    chk("t2_back_rdy", cpu_rdy, 1);
    chk("t2_back_bus_a", bus_a, 16'h1234);

    // 3: forced loader grant; entry edge + DRAIN_MAX edges => 17th negedge
    ldr_req = 1'b1;
    wait_for(1, 40, k);
    chk("t3_force_edges", k, 17);
    chk("t3_bus_d", bus_d, 8'h5A);
    chk("t3_bus_rnw", bus_r_nw, 0);

    // 4: loader revoked after 256 cycles of HCI pending, then regranted
    hci_req = 1'b1;
    wait_for(3, 400, k);
    chk("t4_revoke_edges", k, 256);
    chk("t4_revoke_owner", owner, 3);
    wait_for(0, 10, k);
    chk("t4_hci_after_turn", k, 2);
    repeat (3) @(negedge clk);
    hci_req = 1'b0;
    wait_for(1, 10, k);
    chk("t4_ldr_regrant", k, 3);
    ldr_req = 1'b0;
    wait_for(2, 10, k);
    chk("t4_cpu_back", k, 3);

    // 5: simultaneous requests, then a one-cycle pulse
    cpu_r_nw = 1'b1; hci_req = 1'b1; ldr_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_hci_first", {hci_gnt, ldr_gnt}, 2'b10);
    hci_req = 1'b0;
    wait_for(1, 10, k);
    chk("t5_ldr_second", k, 3);
    ldr_req = 1'b0;
    wait_for(2, 10, k);
    chk("t5_cpu_back", k, 3);
    cpu_r_nw = 1'b0; hci_req = 1'b1;
    @(negedge clk);
    hci_req = 1'b0;
    chk("t5_pulse_drain", cpu_rdy, 0);
    @(negedge clk);
    chk("t5_pulse_rdy", cpu_rdy, 1);
    chk("t5_pulse_gnts", {hci_gnt, ldr_gnt}, 0);

    // 6: asynchronous reset while HCI owns the bus
    cpu_r_nw = 1'b1; hci_req = 1'b1;
    wait_for(0, 10, k);
    chk("t6_hci_gnt", k, 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_gnt", hci_gnt, 0);
    chk("t6_async_rdy", cpu_rdy, 1);
    chk("t6_async_owner", owner, 0);
    @(negedge clk);
    hci_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_after_rdy", cpu_rdy, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
